alu32_result_fifo: RTL and testbench
====================================

# alu32_result_fifo

Downstream capture stage for the 32-bit add/sub ALU: registers each accepted ALU result together with its carry, overflow and zero flags into a small show-ahead FIFO. The FIFO decouples the ALU from a slower consumer (display/bus/writeback). It also keeps sticky status flags, a saturating overflow event counter, and a zero-flag consistency check.

## Interface

- DEPTH, 4, number of FIFO entries; power of two, ≥ 2
- WIDTH, 32, result width; matches the ALU datapath
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-low reset
- in_valid  in  1  ALU outputs below are valid this cycle
- in_ready  out  1  FIFO can accept an entry this cycle
- in_sub_add  in  1  operation tag: 0 add, 1 sub
- in_result  in  WIDTH  ALU result
- in_carry / in_overflow / in_zero  in  1 each  ALU flags
- out_valid  out  1  head entry valid
- out_ready  in  1  consumer takes head entry this cycle
- out_sub_add / out_result / out_carry / out_overflow / out_zero  out  1/WIDTH/1/1/1  head entry fields
- count  out  log2(DEPTH)+1  current occupancy
- sticky_ovf  out  1  set by any accepted entry with overflow=1
- sticky_carry  out  1  set by any accepted entry with carry=1
- zero_err  out  1  sticky; set when accepted in_zero ≠ (in_result == 0)
- ovf_cnt  out  16  count of accepted overflow entries, saturating at 16'hFFFF
- clr_sticky  in  1  clears sticky_ovf, sticky_carry, zero_err, ovf_cnt

## Operation

- push = in_valid & in_ready; pop = out_valid & out_ready
- in_ready = (count < DEPTH) & rst deasserted. It does not depend on out_ready, so there is no push-through when full.
- out_valid = (count != 0). Out fields are driven from the head entry (show-ahead) and are held stable while out_valid & !out_ready.
- When out_valid = 0, out fields are don't-care. The bench must not check them.
- Storage is circular, with wr_ptr/rd_ptr of log2(DEPTH) bits; pointers wrap from DEPTH-1 to 0.
- count: +1 on push only, -1 on pop only, unchanged on push & pop.
- Full (count = DEPTH): in_ready = 0; an in_valid present that cycle is ignored and nothing is written.
- Empty: a pop cannot occur, and out_ready is ignored.
- Flags are stored verbatim; the block never recomputes carry or overflow.
- Status updates happen only on push:
  - sticky_ovf |= in_overflow
  - sticky_carry |= in_carry
  - zero_err |= (in_zero != ~|in_result)
  - ovf_cnt += in_overflow, saturating
- clr_sticky in the same cycle as a setting push: the set wins. The sticky bit ends at 1, and ovf_cnt ends at 1 if that push has overflow, otherwise 0.
- Reset (rst = 0, sampled at the edge):
  - count, pointers, out_valid, all sticky bits and ovf_cnt go to 0.
  - Storage contents need not be cleared.
  - Reset mid-operation discards all queued entries; a push or pop in the reset cycle has no effect.

## Timing

- Push at edge N → entry visible with out_valid = 1 after edge N (cycle N+1). Push-to-output latency is 1 cycle; there is no combinational in→out bypass.
- Pop at edge N → next entry (or out_valid = 0) presented in cycle N+1.
- in_ready falls in the cycle after the push that fills the FIFO. It rises in the cycle after the first pop from full.
- Sustained throughput is 1 entry/cycle when not full, with simultaneous push/pop.
- Status outputs update one cycle after the qualifying push or clr_sticky.
- In the first cycle after rst rises: in_ready = 1, out_valid = 0, count = 0.

## Test plan

- **Reset:** hold rst=0 two cycles with in_valid=1 → in_ready=0, out_valid=0, count=0, ovf_cnt=0. After release, in_ready=1.
- **Single pass:** push result=32'h423A35C6, sub_add=1, flags 0,0,0, with out_ready=0 → next cycle out_valid=1, out_result=32'h423A35C6, count=1. Data is held for 3 cycles. Pulse out_ready → out_valid=0 the following cycle.
- **Fill/overflow/wrap:**
  - Push 5 entries (1..5) back-to-back with out_ready=0 → count=4, in_ready=0 after the 4th; entry 5 is dropped.
  - Drain → outputs 1,2,3,4 in order.
  - Push 6 more → pointers wrap, and order is preserved.
- **Simultaneous push/pop:** at count=2 with in_valid=out_ready=1 for 10 cycles → count stays 2, and outputs match inputs in order with 2-entry lag.
- **Sticky and clear:**
  - Push overflow=1 three times → ovf_cnt=3, sticky_ovf=1.
  - clr_sticky alone → all status 0.
  - clr_sticky together with an overflow push → sticky_ovf=1, ovf_cnt=1.
- **Zero check:** push result=0 with zero=0 → zero_err=1 next cycle. Push result=0 with zero=1 after a clear → zero_err stays 0.

Source files
------------

// File: rtl/alu32_result_fifo.sv
// alu32_result_fifo
//   Capture stage behind the 32-bit add/sub ALU. Each accepted ALU result and
//   its carry/overflow/zero flags go into a small show-ahead FIFO, so a slower
//   consumer can drain them later. The block also keeps sticky status flags,
//   a saturating overflow event counter and a zero-flag consistency check.
//
// Ports
//   clk, rst            clock; synchronous active-low reset
//   in_valid/in_ready   producer handshake (push = in_valid & in_ready)
//   in_sub_add, in_result, in_carry, in_overflow, in_zero   entry fields
//   out_valid/out_ready consumer handshake (pop = out_valid & out_ready)
//   out_sub_add, out_result, out_carry, out_overflow, out_zero  head entry
//   count               current occupancy
//   sticky_ovf, sticky_carry, zero_err, ovf_cnt   status, set only on push
//   clr_sticky          clears status; a setting push in the same cycle wins
module alu32_result_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_sub_add,
    input  logic [WIDTH-1:0]           in_result,
    input  logic                       in_carry,
    input  logic                       in_overflow,
    input  logic                       in_zero,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_sub_add,
    output logic [WIDTH-1:0]           out_result,
    output logic                       out_carry,
    output logic                       out_overflow,
    output logic                       out_zero,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       sticky_ovf,
    output logic                       sticky_carry,
    output logic                       zero_err,
    output logic [15:0]                ovf_cnt,
    input  logic                       clr_sticky
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    // Entry layout: {sub_add, result, carry, overflow, zero}
    localparam int unsigned EW = WIDTH + 4;

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    logic          zero_bad;
    logic [EW-1:0] head;

    assign in_ready  = rst & (count < FULL_COUNT);
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign zero_bad  = in_zero != (in_result == '0);

    assign head         = mem[rd_ptr];
    assign out_sub_add  = head[EW-1];
    assign out_result   = head[WIDTH+2:3];
    assign out_carry    = head[2];
    assign out_overflow = head[1];
    assign out_zero     = head[0];

    // Storage is not reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_sub_add, in_result, in_carry, in_overflow, in_zero};
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Status. A clear drops the old state, but the push of the same cycle
    // still contributes, so a setting push always beats the clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sticky_ovf   <= 1'b0;
            sticky_carry <= 1'b0;
            zero_err     <= 1'b0;
            ovf_cnt      <= '0;
        end else if (clr_sticky) begin
            sticky_ovf   <= push & in_overflow;
            sticky_carry <= push & in_carry;
            zero_err     <= push & zero_bad;
            ovf_cnt      <= {15'd0, push & in_overflow};
        end else if (push) begin
            sticky_ovf   <= sticky_ovf | in_overflow;
            sticky_carry <= sticky_carry | in_carry;
            zero_err     <= zero_err | zero_bad;
            if (in_overflow && (ovf_cnt != 16'hFFFF)) begin
                ovf_cnt <= ovf_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_alu32_result_fifo.sv
// Self-checking bench for alu32_result_fifo (DEPTH=4, WIDTH=32).
// A table of per-cycle vectors covers reset, single pass, sticky/clear and
// the zero check; hand-written sequences cover fill/drop/wrap, sustained
// simultaneous push/pop and reset while entries are queued.
module tb_alu32_result_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sub_add;
    logic [31:0] in_result;
    logic        in_carry;
    logic        in_overflow;
    logic        in_zero;
    logic        out_valid;
    logic        out_ready;
    logic        out_sub_add;
    logic [31:0] out_result;
    logic        out_carry;
    logic        out_overflow;
    logic        out_zero;
    logic [2:0]  count;
    logic        sticky_ovf;
    logic        sticky_carry;
    logic        zero_err;
    logic [15:0] ovf_cnt;
    logic        clr_sticky;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    alu32_result_fifo #(.DEPTH(4), .WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sub_add   (in_sub_add),
        .in_result    (in_result),
        .in_carry     (in_carry),
        .in_overflow  (in_overflow),
        .in_zero      (in_zero),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sub_add  (out_sub_add),
        .out_result   (out_result),
        .out_carry    (out_carry),
        .out_overflow (out_overflow),
        .out_zero     (out_zero),
        .count        (count),
        .sticky_ovf   (sticky_ovf),
        .sticky_carry (sticky_carry),
        .zero_err     (zero_err),
        .ovf_cnt      (ovf_cnt),
        .clr_sticky   (clr_sticky)
    );

    typedef struct {
        logic        rst, iv, sa;
        logic [31:0] res;
        logic        c, o, z, ordy, clr;
        logic        e_rdy, e_vld;
        logic [2:0]  e_cnt;
        logic [35:0] e_head;   // {sub_add, result, carry, overflow, zero}
        logic        e_sov, e_scar, e_zerr;
        logic [15:0] e_oc;
    } vec_t;

    vec_t        vecs[$];
    logic [35:0] q[$];

    function automatic vec_t mk(
        input logic rst_i, input logic iv, input logic sa, input logic [31:0] res,
        input logic c, input logic o, input logic z, input logic ordy, input logic clr,
        input logic e_rdy, input logic e_vld, input logic [2:0] e_cnt,
        input logic [35:0] e_head, input logic e_sov, input logic e_scar,
        input logic e_zerr, input logic [15:0] e_oc);
        vec_t v;
        v.rst = rst_i; v.iv = iv; v.sa = sa; v.res = res;
        v.c = c; v.o = o; v.z = z; v.ordy = ordy; v.clr = clr;
        v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_cnt = e_cnt; v.e_head = e_head;
        v.e_sov = e_sov; v.e_scar = e_scar; v.e_zerr = e_zerr; v.e_oc = e_oc;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [35:0] head_now();
        return {out_sub_add, out_result, out_carry, out_overflow, out_zero};
    endfunction

    // One cycle of a hand sequence, checked against a queue of expected entries.
    task automatic cyc(input logic iv, input logic [31:0] d, input logic ordy, input logic r);
        logic do_push;
        logic do_pop;
        rst = r; in_valid = iv; in_result = d; in_sub_add = d[0];
        in_carry = 1'b0; in_overflow = 1'b0; in_zero = (d == 32'd0);
        out_ready = ordy; clr_sticky = 1'b0;
        do_push = r && iv && (q.size() < 4);
        do_pop  = r && ordy && (q.size() > 0);
        @(posedge clk);
        #1;
        if (!r) begin
            q.delete();
        end else begin
            if (do_pop)  void'(q.pop_front());
            if (do_push) q.push_back({d[0], d, 2'b00, (d == 32'd0)});
        end
        check("seq_count", 64'(count), 64'(q.size()));
        check("seq_out_valid", 64'(out_valid), 64'(q.size() != 0));
        check("seq_in_ready", 64'(in_ready), 64'(r && (q.size() < 4)));
        if (q.size() != 0) check("seq_head", 64'(head_now()), 64'(q[0]));
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_sub_add = 1'b0; in_result = '0;
        in_carry = 1'b0; in_overflow = 1'b0; in_zero = 1'b0;
        out_ready = 1'b0; clr_sticky = 1'b0;

        //            rst iv sa res            c  o  z  ordy clr | rdy vld cnt head                             sov scar zerr oc
        // reset held with in_valid high
        vecs.push_back(mk(0, 1, 0, 32'h5,        1, 1, 0, 1, 0,   0, 0, 3'd0, '0,                               0, 0, 0, 16'd0));
        vecs.push_back(mk(0, 1, 0, 32'h5,        1, 1, 0, 1, 0,   0, 0, 3'd0, '0,                               0, 0, 0, 16'd0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 0, 0, 0,   1, 0, 3'd0, '0,                               0, 0, 0, 16'd0));
        // single pass, held three cycles, then popped
        vecs.push_back(mk(1, 1, 1, 32'h423A35C6, 0, 0, 0, 0, 0,   1, 1, 3'd1, {1'b1, 32'h423A35C6, 3'b000},    0, 0, 0, 16'd0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 0, 0, 0,   1, 1, 3'd1, {1'b1, 32'h423A35C6, 3'b000},    0, 0, 0, 16'd0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 0, 0, 0,   1, 1, 3'd1, {1'b1, 32'h423A35C6, 3'b000},    0, 0, 0, 16'd0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 0, 0, 0,   1, 1, 3'd1, {1'b1, 32'h423A35C6, 3'b000},    0, 0, 0, 16'd0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 0, 1, 0,   1, 0, 3'd0, '0,                               0, 0, 0, 16'd0));
        // three overflow pushes, then clear alone
        vecs.push_back(mk(1, 1, 0, 32'h1,        0, 1, 0, 0, 0,   1, 1, 3'd1, {1'b0, 32'h1, 3'b010},           1, 0, 0, 16'd1));
        vecs.push_back(mk(1, 1, 0, 32'h2,        0, 1, 0, 1, 0,   1, 1, 3'd1, {1'b0, 32'h2, 3'b010},           1, 0, 0, 16'd2));
        vecs.push_back(mk(1, 1, 0, 32'h3,        0, 1, 0, 1, 0,   1, 1, 3'd1, {1'b0, 32'h3, 3'b010},           1, 0, 0, 16'd3));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 0, 1, 1,   1, 0, 3'd0, '0,                               0, 0, 0, 16'd0));
        // clear with a setting push: set wins; clear with a non-setting push: all 0
        vecs.push_back(mk(1, 1, 0, 32'h4,        1, 1, 0, 0, 1,   1, 1, 3'd1, {1'b0, 32'h4, 3'b110},           1, 1, 0, 16'd1));
        vecs.push_back(mk(1, 1, 0, 32'h7,        0, 0, 0, 1, 1,   1, 1, 3'd1, {1'b0, 32'h7, 3'b000},           0, 0, 0, 16'd0));
        // zero check
        vecs.push_back(mk(1, 1, 0, 32'h0,        0, 0, 0, 1, 0,   1, 1, 3'd1, {1'b0, 32'h0, 3'b000},           0, 0, 1, 16'd0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 0, 1, 1,   1, 0, 3'd0, '0,                               0, 0, 0, 16'd0));
        vecs.push_back(mk(1, 1, 0, 32'h0,        0, 0, 1, 1, 0,   1, 1, 3'd1, {1'b0, 32'h0, 3'b001},           0, 0, 0, 16'd0));
        vecs.push_back(mk(1, 1, 1, 32'hFFFFFFFF, 0, 0, 1, 1, 0,   1, 1, 3'd1, {1'b1, 32'hFFFFFFFF, 3'b001},    0, 0, 1, 16'd0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 0, 1, 1,   1, 0, 3'd0, '0,                               0, 0, 0, 16'd0));

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; in_valid = vecs[i].iv; in_sub_add = vecs[i].sa;
            in_result = vecs[i].res; in_carry = vecs[i].c; in_overflow = vecs[i].o;
            in_zero = vecs[i].z; out_ready = vecs[i].ordy; clr_sticky = vecs[i].clr;
            @(posedge clk);
            #1;
            check($sformatf("v%0d_in_ready", i), 64'(in_ready), 64'(vecs[i].e_rdy));
            check($sformatf("v%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].e_vld));
            check($sformatf("v%0d_count", i), 64'(count), 64'(vecs[i].e_cnt));
            check($sformatf("v%0d_sticky_ovf", i), 64'(sticky_ovf), 64'(vecs[i].e_sov));
            check($sformatf("v%0d_sticky_carry", i), 64'(sticky_carry), 64'(vecs[i].e_scar));
            check($sformatf("v%0d_zero_err", i), 64'(zero_err), 64'(vecs[i].e_zerr));
            check($sformatf("v%0d_ovf_cnt", i), 64'(ovf_cnt), 64'(vecs[i].e_oc));
            if (vecs[i].e_vld)
                check($sformatf("v%0d_head", i), 64'(head_now()), 64'(vecs[i].e_head));
        end

        // Fill with five back-to-back pushes; the fifth is dropped.
        for (int i = 1; i <= 5; i++) cyc(1'b1, 32'(i), 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b0, 32'd0, 1'b1, 1'b1);
        // Six more pushes with pops starting later; pointers wrap.
        for (int i = 0; i < 6; i++) cyc(1'b1, 32'h100 + 32'(i), (i >= 2), 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 32'd0, 1'b1, 1'b1);
        // Sustained push/pop at occupancy 2.
        cyc(1'b1, 32'hA0, 1'b0, 1'b1);
        cyc(1'b1, 32'hA1, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) cyc(1'b1, 32'hB0 + 32'(i), 1'b1, 1'b1);
        // Reset with two entries queued and push/pop requested.
        cyc(1'b1, 32'hDEAD, 1'b1, 1'b0);
        cyc(1'b0, 32'd0, 1'b0, 1'b1);
        check("end_zero_err", 64'(zero_err), 64'd0);
        check("end_ovf_cnt", 64'(ovf_cnt), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
